// File: rtl/tour_seq_pkg.sv
// Shared types and constants for the Knight command sequencer.
package tour_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_SENT,
    WAIT_RESP,
    CHECK,
    FIN
  } seq_state_t;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;

  // Knight opcodes live in the top nibble of a command word
  localparam logic [3:0] OP_CAL  = 4'h2;
  localparam logic [3:0] OP_MOVE = 4'h4;
  localparam logic [3:0] OP_TOUR = 4'h6;

  function automatic logic [15:0] knight_cmd(input logic [3:0] op, input logic [11:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Loadable up-counter with clear/enable; expired is raised at LIMIT-1 and the count holds there.
module seq_timeout_cnt #(
  parameter int W     = 22,
  parameter int LIMIT = 2**22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)          cnt <= '0;
    else if (load)           cnt <= load_val;
    else if (en && !expired) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Replays a stored list of 16-bit Knight commands to RemoteComm, waiting for ACK_VAL on each.
// Optional build macro RETRY_EN: a failing entry is re-issued once before err is raised.
module tour_cmd_sequencer
  import tour_seq_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         TIMEOUT_CYC = 2**22,
  parameter logic [7:0] ACK_VAL     = ACK_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [15:0]              wr_cmd,
  input  logic                     clr,
  input  logic                     start,
  output logic [15:0]              cmd,
  output logic                     send_cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH)-1:0] err_idx,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  seq_state_t    state, state_n;
  logic [15:0]   list_q [DEPTH];
  logic [AW-1:0] rd_idx;
  logic [7:0]    resp_q;
  logic [AW:0]   count_post;
  logic          idle, do_wr, do_clr;
  logic          start_go, advance, fail, give_up;
  logic          expired, tmr_clr;

  assign idle    = (state == IDLE);
  assign busy    = !idle;
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_clr  = idle && clr;
  assign do_wr   = idle && wr_en && !full && !clr;
  // start in the same cycle as a write replays the post-write list
  assign count_post = do_clr ? '0 : count + {{AW{1'b0}}, do_wr};
  assign tmr_clr    = (state == WAIT_SENT) && cmd_sent;

  seq_timeout_cnt #(.W(TW), .LIMIT(TIMEOUT_CYC)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (state == WAIT_RESP),
    .expired  (expired)
  );

`ifdef RETRY_EN
  logic retried, retry;
`endif

  always_comb begin
    state_n  = state;
    start_go = 1'b0;
    advance  = 1'b0;
    fail     = 1'b0;
    give_up  = 1'b0;
`ifdef RETRY_EN
    retry    = 1'b0;
`endif
    case (state)
      IDLE:      if (start && count_post != '0) begin
                   state_n  = ISSUE;
                   start_go = 1'b1;
                 end
      ISSUE:     state_n = WAIT_SENT;
      WAIT_SENT: if (cmd_sent) state_n = WAIT_RESP;
      // a response on the expiry cycle still wins
      WAIT_RESP: if (resp_rdy) state_n = CHECK;
                 else if (expired) fail = 1'b1;
      CHECK:     if (resp_q != ACK_VAL) fail = 1'b1;
                 else if ({1'b0, rd_idx} == count - (AW+1)'(1)) state_n = FIN;
                 else begin
                   advance = 1'b1;
                   state_n = ISSUE;
                 end
      FIN:       state_n = IDLE;
      default:   state_n = IDLE;
    endcase
    if (fail) begin
`ifdef RETRY_EN
      if (!retried) begin
        retry   = 1'b1;
        state_n = ISSUE;
      end else begin
        give_up = 1'b1;
        state_n = IDLE;
      end
`else
      give_up = 1'b1;
      state_n = IDLE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      rd_idx   <= '0;
      cmd      <= '0;
      send_cmd <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
      resp_q   <= '0;
    end else begin
      state    <= state_n;
      count    <= count_post;
      send_cmd <= (state == ISSUE);
      done     <= (state == FIN);
      if (do_wr)                           list_q[count[AW-1:0]] <= wr_cmd;
      if (state == ISSUE)                  cmd    <= list_q[rd_idx];
      if (state == WAIT_RESP && resp_rdy)  resp_q <= resp;
      if (start_go)                        rd_idx <= '0;
      else if (advance)                    rd_idx <= rd_idx + AW'(1);
      if (idle && (start || clr))          err    <= 1'b0;
      if (give_up) begin
        err     <= 1'b1;
        err_idx <= rd_idx;
      end
    end
  end

`ifdef RETRY_EN
  always_ff @(posedge clk) begin
    if (rst || start_go || advance) retried <= 1'b0;
    else if (retry)                 retried <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Bench for tour_cmd_sequencer: list/table vectors, directed replays and randomized replays
// against a RemoteComm responder and a list-walking reference model.
module tb_tour_cmd_sequencer;
  import tour_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 1000;
  localparam int AW    = $clog2(DEPTH);
`ifdef RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, wr_en, clr, start, cmd_sent, resp_rdy;
  logic [15:0]   wr_cmd, cmd;
  logic [7:0]    resp;
  logic          send_cmd, busy, done, err, full;
  logic [AW-1:0] err_idx;
  logic [AW:0]   count;

  tour_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .ACK_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd), .clr(clr), .start(start),
    .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [15:0] lst [DEPTH];
  int          nlst = 0;
  logic [8:0]  sc [$];          // responder script; bit 8 set = stay silent
  logic [15:0] exp_q [$], got_q [$];
  int          sent_lat = 2, resp_lat = 3;
  logic        exp_err, exp_tmo;
  int          exp_idx;

  typedef struct {
    logic        wr_en;
    logic [15:0] wr_cmd;
    logic        clr;
    logic        start;
    int          exp_count;
    logic        exp_full;
    logic        exp_busy;
  } vec_t;
  vec_t tv [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input int n);
    clr = 1'b1; tick; clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_cmd = lst[i]; tick;
    end
    wr_en = 1'b0;
    nlst = n;
    check("load_count", 32'(count), 32'(n));
  endtask

  // Walk the list entry by entry, consuming one scripted response per send.
  task automatic model;
    int idx = 0, k = 0;
    bit retried = 1'b0;
    logic [8:0] r;
    exp_q.delete();
    exp_err = 1'b0; exp_tmo = 1'b0; exp_idx = 0;
    while (idx < nlst) begin
      exp_q.push_back(lst[idx]);
      r = (k < sc.size()) ? sc[k] : 9'h100;
      k++;
      if (!r[8] && r[7:0] == 8'hA5) begin
        idx++;
        retried = 1'b0;
      end else if (RETRY && !retried) begin
        retried = 1'b1;
      end else begin
        exp_err = 1'b1; exp_idx = idx; exp_tmo = r[8];
        break;
      end
    end
  endtask

  task automatic run(input string tag, input bit with_wr, input logic [15:0] wr_word);
    int phase = 0, w = 0, k = 0, ndone = 0, sent_edge = 0, err_lat = -1;
    int s_edge, first_p = -1, budget, extra = 0;
    bit fin = 1'b0;
    logic [8:0] r;
    if (with_wr && nlst < DEPTH) begin
      lst[nlst] = wr_word;
      nlst++;
    end
    model();
    got_q.delete();
    budget = 300 + (sc.size() + 1) * (TMO + 40 + resp_lat + sent_lat);
    start = 1'b1; wr_en = with_wr; wr_cmd = wr_word;
    tick;
    start = 1'b0; wr_en = 1'b0;
    s_edge = cyc;
    check({tag, "_busy_at_start"}, 32'(busy), 32'(1));
    check({tag, "_err_cleared"}, 32'(err), 32'(0));
    check({tag, "_count"}, 32'(count), 32'(nlst));
    for (int c = 0; c < budget && !fin; c++) begin
      cmd_sent = 1'b0; resp_rdy = 1'b0;
      if (phase == 1) begin
        if (w == 0) begin cmd_sent = 1'b1; sent_edge = cyc + 1; phase = 2; w = resp_lat; end
        else w--;
      end else if (phase == 2) begin
        if (w == 0) begin
          r = (k < sc.size()) ? sc[k] : 9'h100;
          k++;
          if (!r[8]) begin resp_rdy = 1'b1; resp = r[7:0]; end
          phase = 0;
        end else w--;
      end
      tick;
      if (send_cmd) begin
        got_q.push_back(cmd);
        if (first_p < 0) first_p = cyc;
        phase = 1; w = sent_lat;
      end
      if (done) ndone++;
      if (err && err_lat < 0) err_lat = cyc - sent_edge;
      if (!busy) fin = 1'b1;
    end
    cmd_sent = 1'b0; resp_rdy = 1'b0;
    check({tag, "_finished"}, 32'(fin), 32'(1));
    check({tag, "_start_to_send"}, 32'(first_p - s_edge), 32'(1));
    for (int i = 0; i < 3; i++) begin
      tick;
      if (send_cmd || done || busy) extra++;
    end
    check({tag, "_quiet_after"}, 32'(extra), 32'(0));
    check({tag, "_nsent"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_cmd"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_done"}, 32'(ndone), 32'(exp_err ? 0 : 1));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    if (exp_err) check({tag, "_err_idx"}, 32'(err_idx), 32'(exp_idx));
    if (exp_err && exp_tmo) check({tag, "_tmo_lat"}, 32'(err_lat), 32'(TMO));
  endtask

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick;
      if (send_cmd) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int spurious, n, p;
    logic [7:0] v;
    logic [3:0] op;

    rst = 1'b1; wr_en = 1'b0; clr = 1'b0; start = 1'b0;
    cmd_sent = 1'b0; resp_rdy = 1'b0; wr_cmd = '0; resp = '0;
    tick; tick;
    rst = 1'b0;
    check("rst_cmd", 32'(cmd), 32'(0));
    check("rst_send", 32'(send_cmd), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_err_idx", 32'(err_idx), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    check("rst_full", 32'(full), 32'(0));

    // list fill / overflow / clr / empty start
    for (int i = 0; i < 17; i++) begin
      tv[i].wr_en = 1'b1; tv[i].wr_cmd = 16'h4000 + 16'(i); tv[i].clr = 1'b0; tv[i].start = 1'b0;
      tv[i].exp_count = (i + 1 > 16) ? 16 : i + 1; tv[i].exp_full = (i + 1 >= 16); tv[i].exp_busy = 1'b0;
    end
    tv[17] = '{1'b0, 16'h0,    1'b1, 1'b0, 0, 1'b0, 1'b0};
    tv[18] = '{1'b0, 16'h0,    1'b0, 1'b1, 0, 1'b0, 1'b0};
    tv[19] = '{1'b1, 16'h2111, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    tv[20] = '{1'b1, 16'h2222, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    tv[21] = '{1'b0, 16'h0,    1'b1, 1'b1, 0, 1'b0, 1'b0};
    tv[22] = '{1'b1, 16'h6333, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    for (int i = 0; i < 23; i++) begin
      wr_en = tv[i].wr_en; wr_cmd = tv[i].wr_cmd; clr = tv[i].clr; start = tv[i].start;
      tick;
      check("tv_count", 32'(count), 32'(tv[i].exp_count));
      check("tv_full", 32'(full), 32'(tv[i].exp_full));
      check("tv_busy", 32'(busy), 32'(tv[i].exp_busy));
    end
    wr_en = 1'b0; clr = 1'b0; start = 1'b0;
    spurious = 0;
    for (int i = 0; i < 4; i++) begin tick; if (send_cmd) spurious++; end
    check("empty_start_no_send", 32'(spurious), 32'(0));

    // three-command tour, slow acks, then the same list again
    lst[0] = knight_cmd(OP_CAL, 12'h000);
    lst[1] = knight_cmd(OP_MOVE, 12'h001);
    lst[2] = knight_cmd(OP_TOUR, 12'h022);
    load(3);
    sent_lat = 4; resp_lat = 100;
    sc = '{9'h0A5, 9'h0A5, 9'h0A5};
    run("tour3", 1'b0, 16'h0);
    sent_lat = 1; resp_lat = 2;
    run("repeat", 1'b0, 16'h0);

    sc = '{9'h0A5, 9'h05A, 9'h05A};
    run("nak1", 1'b0, 16'h0);

    sc = '{9'h100, 9'h100};
    run("tmo0", 1'b0, 16'h0);

    sc = '{9'h000, 9'h0A5, 9'h0A5, 9'h0A5, 9'h0A5};
    run("nak0_then_ack", 1'b0, 16'h0);

    load(2);
    sc = '{9'h0A5, 9'h0A5, 9'h0A5};
    run("start_with_wr", 1'b1, knight_cmd(OP_TOUR, 12'h7AB));

    // reset while waiting for entry 1's response
    lst[0] = 16'h2000; lst[1] = 16'h4001; lst[2] = 16'h6022;
    load(3);
    start = 1'b1; tick; start = 1'b0;
    wait_pulse(ok);
    check("rstmid_pulse0", 32'(ok), 32'(1));
    cmd_sent = 1'b1; tick; cmd_sent = 1'b0;
    tick; tick;
    resp_rdy = 1'b1; resp = 8'hA5; tick; resp_rdy = 1'b0;
    wait_pulse(ok);
    check("rstmid_pulse1", 32'(ok), 32'(1));
    check("rstmid_cmd1", 32'(cmd), 32'(16'h4001));
    cmd_sent = 1'b1; tick; cmd_sent = 1'b0;
    tick; tick;
    rst = 1'b1; tick; rst = 1'b0;
    check("rstmid_busy", 32'(busy), 32'(0));
    check("rstmid_send", 32'(send_cmd), 32'(0));
    check("rstmid_count", 32'(count), 32'(0));
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      resp_rdy = (i % 3 == 0); resp = 8'hA5; cmd_sent = (i % 5 == 0);
      tick;
      if (send_cmd || busy || done || err) spurious++;
    end
    resp_rdy = 1'b0; cmd_sent = 1'b0;
    check("rstmid_quiet", 32'(spurious), 32'(0));

    // randomized replays
    for (int it = 0; it < 15; it++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 2))
          0:       op = OP_CAL;
          1:       op = OP_MOVE;
          default: op = OP_TOUR;
        endcase
        lst[i] = knight_cmd(op, 12'($urandom));
      end
      load(n);
      sc.delete();
      for (int j = 0; j < 2 * n + 2; j++) begin
        p = $urandom_range(0, 99);
        if (p < 2) sc.push_back(9'h100);
        else if (p < 12) begin
          v = 8'($urandom);
          if (v == 8'hA5) v = 8'h00;
          sc.push_back({1'b0, v});
        end else sc.push_back(9'h0A5);
      end
      sent_lat = $urandom_range(0, 5);
      resp_lat = $urandom_range(0, 8);
      run("rnd", ($urandom_range(0, 3) == 0), knight_cmd(OP_MOVE, 12'($urandom)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
